grf_wb_arbiter: RTL and testbench

//  Write-side front end of the GRF: merges pipeline W-stage writes and results from a long-latency unit (MDU/

---
 rtl/cpu_pkg.sv | 15 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/grf_wb_arbiter.sv | 103 ++++++++++
 tb/tb_grf_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register/data widths and the write-back request record.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One GRF write: destination register, data and the PC of the producing instruction.
  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

endpackage : cpu_pkg

// File: rtl/wb_fifo.sv
// Long-latency result queue for the GRF write arbiter.
// Circular buffer of DEPTH requests, each with a valid bit. A squash invalidates
// every queued entry whose destination matches squash_a3; invalidated entries stay
// in the queue until they reach the head and are popped (the caller drops them).
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  input  logic             squash_en,
  input  logic [REG_W-1:0] squash_a3,
  output wb_req_t          head_req,
  output logic             head_valid,
  output logic [PTR_W:0]   count,
  output logic [DEPTH-1:0] ent_valid,
  output logic [REG_W-1:0] ent_a3 [DEPTH]
);

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  // Per-entry valid: push sets, pop or a matching squash clears.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      valid_d[gi] = valid_q[gi];
      if (squash_en && valid_q[gi] && (mem_q[gi].a3 == squash_a3)) valid_d[gi] = 1'b0;
      if (pop && (head_q == PTR_W'(gi)))                            valid_d[gi] = 1'b0;
      if (push && (tail_q == PTR_W'(gi)))                           valid_d[gi] = 1'b1;
    end
    assign ent_a3[gi] = mem_q[gi].a3;
  end

  // Pointers wrap naturally at DEPTH (power of two); count includes squashed entries.
  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // Queue state registers; payload storage needs no reset since valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= push_req;
    end
  end

  assign head_req   = mem_q[head_q];
  assign head_valid = valid_q[head_q];
  assign count      = count_q;
  assign ent_valid  = valid_q;

endmodule : wb_fifo

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline W-stage writes win, long-latency unit results
// queue in wb_fifo and issue when the port is idle. A pipeline write to r squashes
// any queued (older) result for r. Exports a pending-register mask for the stall unit.
// Optional macro GRF_WB_TRACE_EN: print each issued non-$0 GRF write.
module grf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = REG_W,   // must match cpu_pkg::REG_W
  parameter int DW    = DATA_W   // must match cpu_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_a3,
  input  logic [DW-1:0] pipe_wd,
  input  logic [DW-1:0] pipe_pc,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_a3,
  input  logic [DW-1:0] lu_wd,
  input  logic [DW-1:0] lu_pc,
  output logic          grf_we,
  output logic [AW-1:0] grf_a3,
  output logic [DW-1:0] grf_wd,
  output logic [DW-1:0] grf_wpc,
  output logic [31:0]   pending_mask
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wb_req_t          head_req, lu_req, out_d, out_q;
  logic             head_valid;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] ent_valid;
  logic [REG_W-1:0] ent_a3 [DEPTH];
  logic             push, pop, pipe_issue;
  logic             grf_we_d, grf_we_q;

  assign lu_req     = '{a3: lu_a3, wd: lu_wd, pc: lu_pc};
  assign lu_ready   = (count < DEPTH_C);
  assign push       = lu_valid && lu_ready && (lu_a3 != REG_ZERO);
  assign pipe_issue = pipe_we && (pipe_a3 != REG_ZERO);
  assign pop        = !pipe_issue && (count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_req   (lu_req),
    .pop        (pop),
    .squash_en  (pipe_issue),
    .squash_a3  (pipe_a3),
    .head_req   (head_req),
    .head_valid (head_valid),
    .count      (count),
    .ent_valid  (ent_valid),
    .ent_a3     (ent_a3)
  );

  // Port select: pipeline first, then a valid FIFO head; otherwise hold the last write.
  always_comb begin
    grf_we_d = 1'b0;
    out_d    = out_q;
    if (pipe_issue) begin
      grf_we_d = 1'b1;
      out_d    = '{a3: pipe_a3, wd: pipe_wd, pc: pipe_pc};
    end else if (pop && head_valid) begin
      grf_we_d = 1'b1;
      out_d    = head_req;
    end
  end

  // Output registers toward the GRF write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we_q <= 1'b0;
      out_q    <= '0;
    end else begin
      grf_we_q <= grf_we_d;
      out_q    <= out_d;
`ifdef GRF_WB_TRACE_EN
      if (grf_we_d && (out_d.a3 != REG_ZERO))
        $display("@%h: $%d <= %h", out_d.pc, out_d.a3, out_d.wd);
`endif
    end
  end

  // Pending mask: OR of destinations of still-valid queued entries; $0 never pending.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i]) pending_mask[ent_a3[i]] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign grf_we  = grf_we_q;
  assign grf_a3  = out_q.a3;
  assign grf_wd  = out_q.wd;
  assign grf_wpc = out_q.pc;

endmodule : grf_wb_arbiter

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter (DEPTH=2): priority, queueing, squash, $0, reset.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd, pipe_pc;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_a3;
  logic [31:0] lu_wd, lu_pc;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_wpc;
  logic [31:0] pending_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_we      (pipe_we),
    .pipe_a3      (pipe_a3),
    .pipe_wd      (pipe_wd),
    .pipe_pc      (pipe_pc),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_a3        (lu_a3),
    .lu_wd        (lu_wd),
    .lu_pc        (lu_pc),
    .grf_we       (grf_we),
    .grf_a3       (grf_a3),
    .grf_wd       (grf_wd),
    .grf_wpc      (grf_wpc),
    .pending_mask (pending_mask)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    pipe_we = we; pipe_a3 = a3; pipe_wd = wd; pipe_pc = pc;
  endtask

  task automatic lu(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    lu_valid = v; lu_a3 = a3; lu_wd = wd; lu_pc = pc;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a3,
                        input logic [31:0] wd, input logic [31:0] pc);
    chk({tag, ".we"}, 32'(grf_we), 32'(we));
    chk({tag, ".a3"}, 32'(grf_a3), 32'(a3));
    chk({tag, ".wd"}, grf_wd, wd);
    chk({tag, ".wpc"}, grf_wpc, pc);
  endtask

  initial begin
    reset = 1'b1;
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    step(); step();

    // 1: reset state, then a single pipeline write with latency 1
    chk_wr("rst", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("rst.mask", pending_mask, 32'h0);
    chk("rst.ready", 32'(lu_ready), 32'd1);
    reset = 1'b0;
    pipe(1'b1, 5'd8, 32'h1234, 32'h3000);
    step();
    chk_wr("t1.pipe", 1'b1, 5'd8, 32'h1234, 32'h3000);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk_wr("t1.hold", 1'b0, 5'd8, 32'h1234, 32'h3000);

    // 2: unit result waits behind 3 pipeline writes
    pipe(1'b1, 5'd10, 32'h1010, 32'h3004);
    lu(1'b1, 5'd9, 32'hAA, 32'h4000);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk_wr($sformatf("t2.busy%0d", i), 1'b1, 5'd10, 32'h1010, 32'h3004);
      chk($sformatf("t2.mask%0d", i), pending_mask, 32'h0000_0200);
      if (i == 2) pipe(1'b0, 5'd0, 32'h0, 32'h0);
      if (i < 2) step();
    end
    step();
    chk_wr("t2.lu", 1'b1, 5'd9, 32'hAA, 32'h4000);
    chk("t2.mask_clr", pending_mask, 32'h0);
    step();
    chk("t2.idle.we", 32'(grf_we), 32'd0);

    // 3: fill the FIFO while the pipe is busy, third push held off, in-order drain
    pipe(1'b1, 5'd10, 32'hC0, 32'h3100);
    lu(1'b1, 5'd11, 32'hB1, 32'h4100);
    step();
    chk("t3.ready1", 32'(lu_ready), 32'd1);
    lu(1'b1, 5'd12, 32'hB2, 32'h4104);
    step();
    chk("t3.full", 32'(lu_ready), 32'd0);
    chk("t3.mask2", pending_mask, 32'h0000_1800);
    lu(1'b1, 5'd13, 32'hB3, 32'h4108);
    step();
    chk("t3.held", 32'(lu_ready), 32'd0);
    chk_wr("t3.pipe", 1'b1, 5'd10, 32'hC0, 32'h3100);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk_wr("t3.d1", 1'b1, 5'd11, 32'hB1, 32'h4100);
    chk("t3.ready_back", 32'(lu_ready), 32'd1);
    chk("t3.mask_d1", pending_mask, 32'h0000_1000);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    chk_wr("t3.d2", 1'b1, 5'd12, 32'hB2, 32'h4104);
    chk("t3.mask_d2", pending_mask, 32'h0000_2000);
    step();
    chk_wr("t3.d3", 1'b1, 5'd13, 32'hB3, 32'h4108);
    step();
    chk("t3.empty.we", 32'(grf_we), 32'd0);
    chk("t3.empty.mask", pending_mask, 32'h0);
    chk("t3.empty.ready", 32'(lu_ready), 32'd1);

    // empty FIFO, no pipe: 2 cycles from lu_valid to grf_we
    lu(1'b1, 5'd7, 32'h77, 32'h4200);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    chk("t3b.wait.we", 32'(grf_we), 32'd0);
    chk("t3b.mask", pending_mask, 32'h0000_0080);
    step();
    chk_wr("t3b.issue", 1'b1, 5'd7, 32'h77, 32'h4200);

    // 4: WAW squash - queued $5 <= 1 is dropped by younger pipe $5 <= 2
    lu(1'b1, 5'd5, 32'h1, 32'h5000);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    chk("t4.mask_set", pending_mask, 32'h0000_0020);
    pipe(1'b1, 5'd5, 32'h2, 32'h5004);
    step();
    chk_wr("t4.pipe", 1'b1, 5'd5, 32'h2, 32'h5004);
    chk("t4.mask_clr", pending_mask, 32'h0);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk_wr("t4.silent", 1'b0, 5'd5, 32'h2, 32'h5004);
    step();
    chk("t4.after.we", 32'(grf_we), 32'd0);
    chk("t4.after.ready", 32'(lu_ready), 32'd1);

    // 5: $0 from both sources is ignored
    lu(1'b1, 5'd0, 32'hDEAD, 32'h6000);
    pipe(1'b1, 5'd0, 32'hBEEF, 32'h6004);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    chk_wr("t5.zero", 1'b0, 5'd5, 32'h2, 32'h5004);
    chk("t5.mask", pending_mask, 32'h0);
    step();
    chk("t5.nodrain.we", 32'(grf_we), 32'd0);

    // 6: reset with 2 queued entries
    pipe(1'b1, 5'd10, 32'hE0, 32'h7000);
    lu(1'b1, 5'd14, 32'hE1, 32'h7100);
    step();
    lu(1'b1, 5'd15, 32'hE2, 32'h7104);
    step();
    lu(1'b0, 5'd0, 32'h0, 32'h0);
    chk("t6.full", 32'(lu_ready), 32'd0);
    chk("t6.mask", pending_mask, 32'h0000_C000);
    pipe(1'b0, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    chk_wr("t6.rst", 1'b0, 5'd0, 32'h0, 32'h0);
    chk("t6.rst.mask", pending_mask, 32'h0);
    chk("t6.rst.ready", 32'(lu_ready), 32'd1);
    reset = 1'b0;
    step();
    chk("t6.nodrain1", 32'(grf_we), 32'd0);
    step();
    chk("t6.nodrain2", 32'(grf_we), 32'd0);
    chk("t6.nodrain.a3", 32'(grf_a3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_grf_wb_arbiter
